// File: rtl/p2_pkg.sv
// Shared opcode constants and instruction field positions for the Project 2 MIPS core.
// Also defines the bubble word that is injected on a stall.
package p2_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;

  localparam logic [4:0] REG_RA = 5'd31;

endpackage

// File: rtl/inst_decode.sv
// Register-usage decode of one instruction word: destination, which sources are read,
// and load/branch/jump class. A destination of $0 is reported as no destination.
module inst_decode
  import p2_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [4:0]  dest_o,
  output logic        uses_rs_o,
  output logic        uses_rt_o,
  output logic        is_load_o,
  output logic        is_branch_o,
  output logic        is_jump_o
);

  logic [5:0] op;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [4:0] dest_raw;
  logic       unused_low_bits;

  assign op = instr_i[OP_HI:OP_LO];
  assign rt = instr_i[RT_HI:RT_LO];
  assign rd = instr_i[RD_HI:RD_LO];
  assign unused_low_bits = ^instr_i[RD_LO-1:0];

  always_comb begin
    dest_raw    = 5'd0;
    uses_rs_o   = 1'b1;
    uses_rt_o   = 1'b0;
    is_load_o   = 1'b0;
    is_branch_o = 1'b0;
    is_jump_o   = 1'b0;
    unique case (op)
      OP_RTYPE: begin
        dest_raw  = rd;
        uses_rt_o = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: dest_raw = rt;
      OP_LW: begin
        dest_raw  = rt;
        is_load_o = 1'b1;
      end
      OP_SW: uses_rt_o = 1'b1;
      OP_BEQ, OP_BNE: begin
        uses_rt_o   = 1'b1;
        is_branch_o = 1'b1;
      end
      OP_J: begin
        uses_rs_o = 1'b0;
        is_jump_o = 1'b1;
      end
      OP_JAL: begin
        dest_raw  = REG_RA;
        uses_rs_o = 1'b0;
        is_jump_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign dest_o = dest_raw;

endmodule

// File: rtl/hazard_pipe.sv
// Pipeline instruction tracker for ID/EX, EX/MEM and MEM/WB with load-use and
// branch-in-ID hazard detection, jump fetch squash and a saturating bubble counter.
module hazard_pipe
  import p2_pkg::*;
#(
  parameter logic [31:0] NOP   = NOP_WORD,
  parameter int          CNT_W = 16
) (
  input  logic             FUCK,
  input  logic             RST,
  input  logic [31:0]      IF_ID,
  input  logic             IF_ID_VALID,
  output logic [31:0]      ID_EX,
  output logic [31:0]      EX_MEM,
  output logic [31:0]      MEM_WB,
  output logic             STALL,
  output logic             FLUSH,
  output logic [CNT_W-1:0] BUBBLES
);

  logic [31:0]      id_ex_q, id_ex_d;
  logic [31:0]      ex_mem_q;
  logic [31:0]      mem_wb_q;
  logic [CNT_W-1:0] bubbles_q, bubbles_d;

  logic [4:0] if_dest, ex_dest, mem_dest;
  logic       if_uses_rs, if_uses_rt, if_is_branch, if_is_jump;
  logic       ex_is_load, mem_is_load;
  logic       unused_if_load;
  logic       unused_ex_rs, unused_ex_rt, unused_ex_branch, unused_ex_jump;
  logic       unused_mem_rs, unused_mem_rt, unused_mem_branch, unused_mem_jump;
  logic [4:0] unused_if_dest;

  inst_decode u_dec_if (
    .instr_i     (IF_ID),
    .dest_o      (if_dest),
    .uses_rs_o   (if_uses_rs),
    .uses_rt_o   (if_uses_rt),
    .is_load_o   (unused_if_load),
    .is_branch_o (if_is_branch),
    .is_jump_o   (if_is_jump)
  );

  inst_decode u_dec_ex (
    .instr_i     (id_ex_q),
    .dest_o      (ex_dest),
    .uses_rs_o   (unused_ex_rs),
    .uses_rt_o   (unused_ex_rt),
    .is_load_o   (ex_is_load),
    .is_branch_o (unused_ex_branch),
    .is_jump_o   (unused_ex_jump)
  );

  inst_decode u_dec_mem (
    .instr_i     (ex_mem_q),
    .dest_o      (mem_dest),
    .uses_rs_o   (unused_mem_rs),
    .uses_rt_o   (unused_mem_rt),
    .is_load_o   (mem_is_load),
    .is_branch_o (unused_mem_branch),
    .is_jump_o   (unused_mem_jump)
  );

  assign unused_if_dest = if_dest;

  logic [4:0] if_rs, if_rt;
  logic       hit_ex, hit_mem;
  logic       h_load_use, h_branch_alu, h_branch_load;

  assign if_rs = IF_ID[RS_HI:RS_LO];
  assign if_rt = IF_ID[RT_HI:RT_LO];

  // dest is already 0 for "no destination", so a $0 source can never match.
  assign hit_ex  = (ex_dest != 5'd0) &&
                   ((if_uses_rs && (if_rs == ex_dest)) || (if_uses_rt && (if_rt == ex_dest)));
  assign hit_mem = (mem_dest != 5'd0) &&
                   ((if_uses_rs && (if_rs == mem_dest)) || (if_uses_rt && (if_rt == mem_dest)));

  assign h_load_use    = ex_is_load && hit_ex;
  assign h_branch_alu  = if_is_branch && hit_ex;
  assign h_branch_load = if_is_branch && mem_is_load && hit_mem;

  assign STALL = IF_ID_VALID && (h_load_use || h_branch_alu || h_branch_load);
  assign FLUSH = IF_ID_VALID && !STALL && if_is_jump;

  always_comb begin
    id_ex_d   = (STALL || !IF_ID_VALID) ? NOP : IF_ID;
    bubbles_d = bubbles_q;
    if (STALL && (bubbles_q != {CNT_W{1'b1}})) begin
      bubbles_d = bubbles_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge FUCK) begin
    if (RST) begin
      id_ex_q   <= NOP;
      ex_mem_q  <= NOP;
      mem_wb_q  <= NOP;
      bubbles_q <= '0;
    end else begin
      id_ex_q   <= id_ex_d;
      ex_mem_q  <= id_ex_q;
      mem_wb_q  <= ex_mem_q;
      bubbles_q <= bubbles_d;
    end
  end

  assign ID_EX   = id_ex_q;
  assign EX_MEM  = ex_mem_q;
  assign MEM_WB  = mem_wb_q;
  assign BUBBLES = bubbles_q;

endmodule

// File: tb/tb_hazard_pipe.sv
// Bench for hazard_pipe: directed vector table followed by randomized traffic
// checked against an opcode-rule reference model; a 4-bit-counter copy exercises saturation.
module tb_hazard_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ifid;
  logic        v;

  logic [31:0] idex, exm, mwb;
  logic        stall, flush;
  logic [15:0] bub;

  logic [31:0] idex4, exm4, mwb4;
  logic        stall4, flush4;
  logic [3:0]  bub4;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hazard_pipe #(.NOP(32'h0), .CNT_W(16)) dut (
    .FUCK(clk), .RST(rst), .IF_ID(ifid), .IF_ID_VALID(v),
    .ID_EX(idex), .EX_MEM(exm), .MEM_WB(mwb),
    .STALL(stall), .FLUSH(flush), .BUBBLES(bub)
  );

  hazard_pipe #(.NOP(32'h0), .CNT_W(4)) dut4 (
    .FUCK(clk), .RST(rst), .IF_ID(ifid), .IF_ID_VALID(v),
    .ID_EX(idex4), .EX_MEM(exm4), .MEM_WB(mwb4),
    .STALL(stall4), .FLUSH(flush4), .BUBBLES(bub4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model (opcode rules) ----------------
  function automatic int m_dest(input logic [31:0] w);
    int op = int'(w[31:26]);
    if (op == 'h00) return int'(w[15:11]);
    if (op inside {'h08, 'h09, 'h0A, 'h0C, 'h0D, 'h0F, 'h23}) return int'(w[20:16]);
    if (op == 'h03) return 31;
    return 0;
  endfunction

  function automatic bit m_reads(input logic [31:0] w, input int r);
    int op = int'(w[31:26]);
    bit rs_hit = (int'(w[25:21]) == r);
    bit rt_hit = (int'(w[20:16]) == r);
    if (r == 0) return 1'b0;
    if (op inside {'h02, 'h03}) return 1'b0;
    if (op inside {'h00, 'h2B, 'h04, 'h05}) return rs_hit || rt_hit;
    return rs_hit;
  endfunction

  function automatic bit m_stall(input logic [31:0] w, input logic vv,
                                 input logic [31:0] in_ex, input logic [31:0] in_mem);
    bit br = (w[31:26] == 6'h04) || (w[31:26] == 6'h05);
    if (!vv) return 1'b0;
    if (in_ex[31:26] == 6'h23 && m_reads(w, m_dest(in_ex))) return 1'b1;
    if (br && m_reads(w, m_dest(in_ex))) return 1'b1;
    if (br && in_mem[31:26] == 6'h23 && m_reads(w, m_dest(in_mem))) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int sat(input int n, input int maxv);
    return (n > maxv) ? maxv : n;
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    logic        r;
    logic [31:0] w;
    logic        vv;
    logic        s;
    logic        f;
    logic [31:0] idex;
    int          b;
  } vec_t;

  vec_t tbl[$];

  logic [5:0] ops [12] = '{6'h00, 6'h08, 6'h0C, 6'h0F, 6'h23, 6'h23,
                           6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h0D};

  initial begin
    logic [31:0] p_idex, p_exm;
    logic [31:0] m_idex, m_exm, m_mwb;
    int          m_tot;
    logic        es, ef, held;

    tbl.push_back('{1'b0, 32'h8C22_0000, 1'b1, 1'b0, 1'b0, 32'h8C22_0000, 0});
    tbl.push_back('{1'b0, 32'h0044_1820, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 1});
    tbl.push_back('{1'b0, 32'h0044_1820, 1'b1, 1'b0, 1'b0, 32'h0044_1820, 1});
    tbl.push_back('{1'b0, 32'h0022_1820, 1'b1, 1'b0, 1'b0, 32'h0022_1820, 1});
    tbl.push_back('{1'b0, 32'h0064_2822, 1'b1, 1'b0, 1'b0, 32'h0064_2822, 1});
    tbl.push_back('{1'b0, 32'h0022_1820, 1'b1, 1'b0, 1'b0, 32'h0022_1820, 1});
    tbl.push_back('{1'b0, 32'h1060_0000, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 2});
    tbl.push_back('{1'b0, 32'h1060_0000, 1'b1, 1'b0, 1'b0, 32'h1060_0000, 2});
    tbl.push_back('{1'b0, 32'h8C23_0000, 1'b1, 1'b0, 1'b0, 32'h8C23_0000, 2});
    tbl.push_back('{1'b0, 32'h1060_0000, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 3});
    tbl.push_back('{1'b0, 32'h1060_0000, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 4});
    tbl.push_back('{1'b0, 32'h1060_0000, 1'b1, 1'b0, 1'b0, 32'h1060_0000, 4});
    tbl.push_back('{1'b0, 32'h0800_0010, 1'b1, 1'b0, 1'b1, 32'h0800_0010, 4});
    tbl.push_back('{1'b0, 32'h0800_0010, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 4});
    tbl.push_back('{1'b0, 32'h8C20_0000, 1'b1, 1'b0, 1'b0, 32'h8C20_0000, 4});
    tbl.push_back('{1'b0, 32'h0000_1820, 1'b1, 1'b0, 1'b0, 32'h0000_1820, 4});
    tbl.push_back('{1'b0, 32'h8C22_0000, 1'b1, 1'b0, 1'b0, 32'h8C22_0000, 4});
    tbl.push_back('{1'b1, 32'h0044_1820, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 0});
    tbl.push_back('{1'b0, 32'h0044_1820, 1'b1, 1'b0, 1'b0, 32'h0044_1820, 0});

    // reset state
    rst = 1'b1; ifid = 32'h0; v = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #2;
    chk("reset ID_EX", idex, 32'h0);
    chk("reset EX_MEM", exm, 32'h0);
    chk("reset MEM_WB", mwb, 32'h0);
    chk("reset BUBBLES", {16'h0, bub}, 32'h0);
    chk("reset STALL", {31'h0, stall}, 32'h0);
    chk("reset FLUSH", {31'h0, flush}, 32'h0);

    p_idex = 32'h0; p_exm = 32'h0;
    foreach (tbl[i]) begin
      rst = tbl[i].r; ifid = tbl[i].w; v = tbl[i].vv;
      #2;
      chk($sformatf("tbl[%0d] STALL", i), {31'h0, stall}, {31'h0, tbl[i].s});
      chk($sformatf("tbl[%0d] FLUSH", i), {31'h0, flush}, {31'h0, tbl[i].f});
      @(posedge clk); #1;
      chk($sformatf("tbl[%0d] ID_EX", i), idex, tbl[i].idex);
      chk($sformatf("tbl[%0d] EX_MEM", i), exm, tbl[i].r ? 32'h0 : p_idex);
      chk($sformatf("tbl[%0d] MEM_WB", i), mwb, tbl[i].r ? 32'h0 : p_exm);
      chk($sformatf("tbl[%0d] BUBBLES", i), {16'h0, bub}, 32'(tbl[i].b));
      chk($sformatf("tbl[%0d] BUBBLES4", i), {28'h0, bub4}, 32'(sat(tbl[i].b, 15)));
      p_exm  = tbl[i].r ? 32'h0 : p_idex;
      p_idex = tbl[i].idex;
    end

    // randomized traffic against the model
    rst = 1'b1; v = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_idex = 32'h0; m_exm = 32'h0; m_mwb = 32'h0; m_tot = 0;
    held = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!held) begin
        ifid = {ops[$urandom_range(0, 11)], 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 11'($urandom)};
        v = ($urandom_range(0, 9) != 0);
      end
      rst = ($urandom_range(0, 299) == 0);
      es = m_stall(ifid, v, m_idex, m_exm);
      ef = v && !es && (ifid[31:26] == 6'h02 || ifid[31:26] == 6'h03);
      #2;
      chk("rnd STALL", {31'h0, stall}, {31'h0, es});
      chk("rnd FLUSH", {31'h0, flush}, {31'h0, ef});
      @(posedge clk); #1;
      if (rst) begin
        m_idex = 32'h0; m_exm = 32'h0; m_mwb = 32'h0; m_tot = 0;
      end else begin
        m_mwb  = m_exm;
        m_exm  = m_idex;
        m_idex = (es || !v) ? 32'h0 : ifid;
        if (es) m_tot++;
      end
      chk("rnd ID_EX", idex, m_idex);
      chk("rnd EX_MEM", exm, m_exm);
      chk("rnd MEM_WB", mwb, m_mwb);
      chk("rnd BUBBLES", {16'h0, bub}, 32'(sat(m_tot, 65535)));
      chk("rnd BUBBLES4", {28'h0, bub4}, 32'(sat(m_tot, 15)));
      held = es && !rst;
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
